// File: rtl/car_kinematics.sv
// Vehicle kinematics engine: each accepted frame tick updates speed and heading (VEL),
// then integrates Q.6 fixed-point position along the heading with arena-wall clamping (POS).
module car_kinematics #(
  parameter int         POS_W       = 16,
  parameter int         SPD_W       = 8,
  parameter logic [2:0] RUN_STATE   = 3'd1,
  parameter int         ACCEL       = 5,
  parameter int         BOOST_ACCEL = 20,
  parameter int         MAX_SPEED   = 60,
  parameter int         BOOST_MAX   = 100,
  parameter int         REV_MAX     = 30,
  parameter int         DRAG        = 5,
  parameter int         TURN_DIV    = 4,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 639,
  parameter int         Y_MIN       = 0,
  parameter int         Y_MAX       = 479,
  parameter int         START_X     = 160,
  parameter int         START_Y     = 120,
  parameter logic [3:0] START_ANGLE = 4'd0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic [2:0]              i_state,
  input  logic [2:0]              i_operation_code,
  input  logic                    i_boost,
  output logic [POS_W-1:0]        o_pos_x,
  output logic [POS_W-1:0]        o_pos_y,
  output logic [3:0]              o_angle_index,
  output logic signed [SPD_W-1:0] o_speed,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_collision
);

  localparam int PW  = POS_W + 6;
  localparam int SW  = POS_W + 8;
  localparam int VW  = SPD_W + 2;
  localparam int DW  = SPD_W + 8;
  localparam int TCW = (TURN_DIV > 1) ? $clog2(TURN_DIV) : 1;

  localparam logic [2:0] OP_NIL   = 3'd0;
  localparam logic [2:0] OP_FWD   = 3'd1;
  localparam logic [2:0] OP_BWD   = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  localparam logic signed [VW-1:0] K_ACC   = VW'(ACCEL);
  localparam logic signed [VW-1:0] K_BACC  = VW'(BOOST_ACCEL);
  localparam logic signed [VW-1:0] K_MAX   = VW'(MAX_SPEED);
  localparam logic signed [VW-1:0] K_BMAX  = VW'(BOOST_MAX);
  localparam logic signed [VW-1:0] K_NREV  = VW'(-REV_MAX);
  localparam logic signed [VW-1:0] K_DRAG  = VW'(DRAG);
  localparam logic signed [VW-1:0] K_NDRAG = VW'(-DRAG);
  localparam logic [TCW-1:0]       K_TLAST = TCW'(TURN_DIV - 1);

  // Upper bounds admit any fraction inside the last pixel; leaving that pixel clamps.
  localparam logic signed [SW-1:0] K_XLO = SW'(X_MIN * 64);
  localparam logic signed [SW-1:0] K_XHI = SW'(X_MAX * 64 + 63);
  localparam logic signed [SW-1:0] K_YLO = SW'(Y_MIN * 64);
  localparam logic signed [SW-1:0] K_YHI = SW'(Y_MAX * 64 + 63);
  localparam logic [PW-1:0] K_XMIN_Q   = PW'(X_MIN * 64);
  localparam logic [PW-1:0] K_XMAX_Q   = PW'(X_MAX * 64);
  localparam logic [PW-1:0] K_YMIN_Q   = PW'(Y_MIN * 64);
  localparam logic [PW-1:0] K_YMAX_Q   = PW'(Y_MAX * 64);
  localparam logic [PW-1:0] K_XSTART_Q = PW'(START_X * 64);
  localparam logic [PW-1:0] K_YSTART_Q = PW'(START_Y * 64);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VEL  = 2'd1,
    ST_POS  = 2'd2
  } state_t;

  function automatic logic signed [7:0] cos_lut(input logic [3:0] idx);
    logic signed [7:0] v;
    case (idx)
      4'd0:    v = 8'sd64;
      4'd1:    v = 8'sd59;
      4'd2:    v = 8'sd45;
      4'd3:    v = 8'sd24;
      4'd4:    v = 8'sd0;
      4'd5:    v = -8'sd24;
      4'd6:    v = -8'sd45;
      4'd7:    v = -8'sd59;
      4'd8:    v = -8'sd64;
      4'd9:    v = -8'sd59;
      4'd10:   v = -8'sd45;
      4'd11:   v = -8'sd24;
      4'd12:   v = 8'sd0;
      4'd13:   v = 8'sd24;
      4'd14:   v = 8'sd45;
      4'd15:   v = 8'sd59;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

  // Returns {clamped, new_position}; a clamp lands on the bound with zero fraction.
  function automatic logic [PW:0] clamp_axis(input logic signed [SW-1:0] sum,
                                             input logic signed [SW-1:0] lo,
                                             input logic signed [SW-1:0] hi,
                                             input logic [PW-1:0]        min_q,
                                             input logic [PW-1:0]        max_q);
    logic [PW:0] r;
    if (sum < lo) begin
      r = {1'b1, min_q};
    end else if (sum > hi) begin
      r = {1'b1, max_q};
    end else begin
      r = {1'b0, sum[PW-1:0]};
    end
    return r;
  endfunction

  state_t                  r_st, w_st_nxt;
  logic                    r_pend, w_pend_nxt;
  logic                    r_busy;
  logic [2:0]              r_op;
  logic                    r_boost;
  logic signed [SPD_W-1:0] r_speed;
  logic [3:0]              r_angle;
  logic [TCW-1:0]          r_turn_cnt;
  logic                    r_turn_dir;
  logic [PW-1:0]           r_pos_x, r_pos_y;
  logic                    r_frame_done, r_collision;

  logic                    w_run_tick, w_accept;
  logic signed [VW-1:0]    w_spd, w_cap, w_acc, w_dec, w_inc, w_bwd, w_rise, w_vel;
  logic signed [SPD_W-1:0] w_spd_nxt;
  logic                    w_is_turn, w_dir;
  logic [TCW-1:0]          w_cnt_eff, w_cnt_nxt;
  logic [3:0]              w_ang_nxt;
  logic                    w_dir_nxt;
  logic signed [7:0]       w_cos, w_sin;
  logic signed [DW-1:0]    w_spd_dw, w_cos_dw, w_sin_dw, w_mul_x, w_mul_y, w_dx, w_dy;
  logic signed [SW-1:0]    w_sum_x, w_sum_y;
  logic [PW-1:0]           w_new_x, w_new_y;
  logic                    w_clamp_x, w_clamp_y;

  // A tick is taken when idle, or parked as the single pending update while busy.
  assign w_run_tick = i_tick & (i_state == RUN_STATE);
  assign w_accept   = w_run_tick & ((r_st == ST_IDLE) | ~r_pend);

  // Next-state logic for the IDLE -> VEL -> POS sequence with pending restart.
  always_comb begin
    w_st_nxt   = r_st;
    w_pend_nxt = r_pend;
    case (r_st)
      ST_IDLE: begin
        w_pend_nxt = 1'b0;
        if (w_run_tick) w_st_nxt = ST_VEL;
        else            w_st_nxt = ST_IDLE;
      end
      ST_VEL: begin
        w_st_nxt = ST_POS;
        if (w_accept) w_pend_nxt = 1'b1;
        else          w_pend_nxt = r_pend;
      end
      ST_POS: begin
        w_pend_nxt = 1'b0;
        if (r_pend || w_accept) w_st_nxt = ST_VEL;
        else                    w_st_nxt = ST_IDLE;
      end
      default: begin
        w_st_nxt   = ST_IDLE;
        w_pend_nxt = 1'b0;
      end
    endcase
  end

  assign w_spd  = {{2{r_speed[SPD_W-1]}}, r_speed};
  assign w_cap  = r_boost ? K_BMAX : K_MAX;
  assign w_acc  = r_boost ? K_BACC : K_ACC;
  assign w_dec  = w_spd - K_DRAG;
  assign w_inc  = w_spd + w_acc;
  assign w_bwd  = w_spd - K_ACC;
  assign w_rise = w_spd + K_DRAG;

  // Speed rule: accelerate/decay toward the active cap, reverse with its own cap, else coast to zero.
  always_comb begin
    w_vel = w_spd;
    case (r_op)
      OP_FWD: begin
        if (w_spd > w_cap) begin
          if (w_dec > w_cap) w_vel = w_dec;
          else               w_vel = w_cap;
        end else begin
          if (w_inc < w_cap) w_vel = w_inc;
          else               w_vel = w_cap;
        end
      end
      OP_BWD: begin
        if (w_bwd > K_NREV) w_vel = w_bwd;
        else                w_vel = K_NREV;
      end
      default: begin
        if (w_spd > K_DRAG)       w_vel = w_dec;
        else if (w_spd < K_NDRAG) w_vel = w_rise;
        else                      w_vel = {VW{1'b0}};
      end
    endcase
  end

  assign w_spd_nxt = w_vel[SPD_W-1:0];
  assign w_is_turn = (r_op == OP_LEFT) | (r_op == OP_RIGHT);
  assign w_dir     = (r_op == OP_RIGHT);
  assign w_cnt_eff = (w_dir == r_turn_dir) ? r_turn_cnt : {TCW{1'b0}};

  // Heading steps once per TURN_DIV held turn ticks; a direction change restarts the count.
  always_comb begin
    w_cnt_nxt = {TCW{1'b0}};
    w_ang_nxt = r_angle;
    w_dir_nxt = r_turn_dir;
    if (w_is_turn) begin
      w_dir_nxt = w_dir;
      if (w_cnt_eff == K_TLAST) begin
        w_cnt_nxt = {TCW{1'b0}};
        w_ang_nxt = w_dir ? (r_angle + 4'd1) : (r_angle - 4'd1);
      end else begin
        w_cnt_nxt = w_cnt_eff + TCW'(1);
        w_ang_nxt = r_angle;
      end
    end else begin
      w_cnt_nxt = {TCW{1'b0}};
      w_ang_nxt = r_angle;
      w_dir_nxt = r_turn_dir;
    end
  end

  // speed (1/8 px) * Q1.6 trig is 1/512 px; >>>3 brings it to the 1/64 px position grid.
  assign w_cos    = cos_lut(r_angle);
  assign w_sin    = cos_lut(r_angle + 4'd12);
  assign w_spd_dw = {{8{r_speed[SPD_W-1]}}, r_speed};
  assign w_cos_dw = {{SPD_W{w_cos[7]}}, w_cos};
  assign w_sin_dw = {{SPD_W{w_sin[7]}}, w_sin};
  assign w_mul_x  = w_spd_dw * w_cos_dw;
  assign w_mul_y  = w_spd_dw * w_sin_dw;
  assign w_dx     = w_mul_x >>> 3'd3;
  assign w_dy     = w_mul_y >>> 3'd3;
  assign w_sum_x  = $signed({2'b00, r_pos_x}) + $signed({{(SW-DW){w_dx[DW-1]}}, w_dx});
  assign w_sum_y  = $signed({2'b00, r_pos_y}) + $signed({{(SW-DW){w_dy[DW-1]}}, w_dy});

  assign {w_clamp_x, w_new_x} = clamp_axis(w_sum_x, K_XLO, K_XHI, K_XMIN_Q, K_XMAX_Q);
  assign {w_clamp_y, w_new_y} = clamp_axis(w_sum_y, K_YLO, K_YHI, K_YMIN_Q, K_YMAX_Q);

  // State, kinematic registers and frame pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st         <= ST_IDLE;
      r_pend       <= 1'b0;
      r_busy       <= 1'b0;
      r_op         <= OP_NIL;
      r_boost      <= 1'b0;
      r_speed      <= {SPD_W{1'b0}};
      r_angle      <= START_ANGLE;
      r_turn_cnt   <= {TCW{1'b0}};
      r_turn_dir   <= 1'b0;
      r_pos_x      <= K_XSTART_Q;
      r_pos_y      <= K_YSTART_Q;
      r_frame_done <= 1'b0;
      r_collision  <= 1'b0;
    end else begin
      r_st         <= w_st_nxt;
      r_pend       <= w_pend_nxt;
      r_busy       <= (w_st_nxt != ST_IDLE);
      r_frame_done <= 1'b0;
      r_collision  <= 1'b0;
      if (w_accept) begin
        r_op    <= i_operation_code;
        r_boost <= i_boost;
      end
      case (r_st)
        ST_VEL: begin
          r_speed    <= w_spd_nxt;
          r_angle    <= w_ang_nxt;
          r_turn_cnt <= w_cnt_nxt;
          r_turn_dir <= w_dir_nxt;
        end
        ST_POS: begin
          r_pos_x      <= w_new_x;
          r_pos_y      <= w_new_y;
          r_frame_done <= 1'b1;
          r_collision  <= w_clamp_x | w_clamp_y;
          if (w_clamp_x | w_clamp_y) r_speed <= {SPD_W{1'b0}};
        end
        default: ;
      endcase
    end
  end

  assign o_pos_x       = r_pos_x[PW-1:6];
  assign o_pos_y       = r_pos_y[PW-1:6];
  assign o_angle_index = r_angle;
  assign o_speed       = r_speed;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_collision   = r_collision;

endmodule

// File: tb/tb_car_kinematics.sv
// Bench for car_kinematics: table of directed tick vectors, hand-written timing sequences,
// and randomized ticks checked against an arithmetic model of the vehicle.
module tb_car_kinematics;

  logic clk = 1'b0;
  logic rst, tick, boost;
  logic [2:0] state, op;

  logic [15:0]       pos_x0, pos_y0, pos_x1, pos_y1;
  logic [3:0]        ang0, ang1;
  logic signed [7:0] speed0, speed1;
  logic              busy0, done0, col0, busy1, done1, col1;

  always #5 clk = ~clk;

  car_kinematics u_dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_state(state),
    .i_operation_code(op), .i_boost(boost),
    .o_pos_x(pos_x0), .o_pos_y(pos_y0), .o_angle_index(ang0), .o_speed(speed0),
    .o_busy(busy0), .o_frame_done(done0), .o_collision(col0)
  );

  car_kinematics #(.START_X(1)) u_dut_edge (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_state(state),
    .i_operation_code(op), .i_boost(boost),
    .o_pos_x(pos_x1), .o_pos_y(pos_y1), .o_angle_index(ang1), .o_speed(speed1),
    .o_busy(busy1), .o_frame_done(done1), .o_collision(col1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  typedef struct {
    logic [2:0] op;
    logic       boost;
    int         spd;
    int         ang;
    int         px;   // -1: position not checked for this vector
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] o, input logic b, input int s, input int a, input int p);
    vec_t v;
    v.op = o; v.boost = b; v.spd = s; v.ang = a; v.px = p;
    tbl.push_back(v);
  endtask

  // Reference model: position in 1/64 px, speed in 1/8 px per tick.
  int cos_t[16] = '{64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24, 0, 24, 45, 59};
  int m_px, m_py, m_spd, m_ang, m_tc, m_dir;

  task automatic model_reset();
    m_px = 160 * 64; m_py = 120 * 64; m_spd = 0; m_ang = 0; m_tc = 0; m_dir = 0;
  endtask

  task automatic model_step(input int o, input int b, output int col);
    int cap, acc, dx, dy, nx, ny, d;
    cap = b ? 100 : 60;
    acc = b ? 20 : 5;
    if (o == 1) begin
      if (m_spd > cap) m_spd = (m_spd - 5 > cap) ? m_spd - 5 : cap;
      else             m_spd = (m_spd + acc < cap) ? m_spd + acc : cap;
    end else if (o == 2) begin
      m_spd = (m_spd - 5 > -30) ? m_spd - 5 : -30;
    end else if (m_spd > 0) begin
      m_spd = (m_spd > 5) ? m_spd - 5 : 0;
    end else begin
      m_spd = (m_spd < -5) ? m_spd + 5 : 0;
    end
    if (o == 3 || o == 4) begin
      d = (o == 4) ? 1 : 0;
      if (d != m_dir) m_tc = 0;
      m_dir = d;
      m_tc++;
      if (m_tc == 4) begin
        m_ang = (m_ang + (d ? 1 : 15)) % 16;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
    dx = (m_spd * cos_t[m_ang]) >>> 3;
    dy = (m_spd * cos_t[(m_ang + 12) % 16]) >>> 3;
    nx = m_px + dx;
    ny = m_py + dy;
    col = 0;
    if (nx < 0)              begin nx = 0;        col = 1; end
    else if (nx >= 640 * 64) begin nx = 639 * 64; col = 1; end
    if (ny < 0)              begin ny = 0;        col = 1; end
    else if (ny >= 480 * 64) begin ny = 479 * 64; col = 1; end
    m_px = nx;
    m_py = ny;
    if (col != 0) m_spd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle tick, then wait a bounded number of cycles for frame_done.
  task automatic tick_and_wait(input logic [2:0] o, input logic b, input logic [2:0] st,
                               output int got_done);
    @(negedge clk);
    op = o; boost = b; state = st; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    got_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done0) begin
        got_done = 1;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got, nd, seen, mcol, rc, v;
    logic [2:0] rop, rst_st;
    logic rb;
    rst = 1'b1; tick = 1'b0; state = 3'd1; op = 3'd0; boost = 1'b0;

    add(3'd1, 1'b0, 5, 0, 160);  add(3'd1, 1'b0, 10, 0, 161); add(3'd1, 1'b0, 15, 0, 163);
    add(3'd0, 1'b0, 10, 0, 165); add(3'd0, 1'b0, 5, 0, 165);  add(3'd0, 1'b0, 0, 0, 165);
    add(3'd0, 1'b0, 0, 0, 165);
    add(3'd1, 1'b1, 20, 0, 168); add(3'd1, 1'b1, 40, 0, 173); add(3'd1, 1'b1, 60, 0, 180);
    add(3'd1, 1'b1, 80, 0, 190); add(3'd1, 1'b1, 100, 0, 203); add(3'd1, 1'b1, 100, 0, 215);
    for (int s = 95; s >= 60; s -= 5) add(3'd1, 1'b0, s, 0, -1);
    add(3'd1, 1'b0, 60, 0, 300);
    add(3'd3, 1'b0, 55, 0, -1);  add(3'd3, 1'b0, 50, 0, -1);  add(3'd3, 1'b0, 45, 0, -1);
    add(3'd3, 1'b0, 40, 15, -1); add(3'd3, 1'b0, 35, 15, -1); add(3'd3, 1'b0, 30, 15, -1);
    add(3'd3, 1'b0, 25, 15, -1); add(3'd3, 1'b0, 20, 14, -1);
    add(3'd3, 1'b0, 15, 14, -1); add(3'd3, 1'b0, 10, 14, -1);
    add(3'd4, 1'b0, 5, 14, -1);  add(3'd4, 1'b0, 0, 14, -1);  add(3'd4, 1'b0, 0, 14, -1);
    add(3'd4, 1'b0, 0, 15, -1);
    add(3'd4, 1'b0, 0, 15, -1);  add(3'd4, 1'b0, 0, 15, -1);  add(3'd4, 1'b0, 0, 15, -1);
    add(3'd4, 1'b0, 0, 0, -1);
    add(3'd1, 1'b0, 5, 0, -1);   add(3'd6, 1'b0, 0, 0, -1);

    do_reset();
    chk("reset_speed", speed0, 0);
    chk("reset_pos_x", pos_x0, 160);
    chk("reset_pos_y", pos_y0, 120);
    chk("reset_angle", ang0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_edge_pos_x", pos_x1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      tick_and_wait(tbl[i].op, tbl[i].boost, 3'd1, got);
      chk($sformatf("vec%0d_done", i), got, 1);
      chk($sformatf("vec%0d_speed", i), speed0, tbl[i].spd);
      chk($sformatf("vec%0d_angle", i), ang0, tbl[i].ang);
      chk($sformatf("vec%0d_col", i), col0, 0);
      if (tbl[i].px >= 0) chk($sformatf("vec%0d_pos_x", i), pos_x0, tbl[i].px);
    end

    // Latency: speed moves one cycle after the tick edge, frame_done one cycle later.
    @(negedge clk);
    op = 3'd1; boost = 1'b0; state = 3'd1; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("lat_busy_n", busy0, 1);
    chk("lat_speed_n", speed0, 0);
    chk("lat_done_n", done0, 0);
    @(negedge clk);
    chk("lat_speed_n1", speed0, 5);
    chk("lat_done_n1", done0, 0);
    @(negedge clk);
    chk("lat_done_n2", done0, 1);
    chk("lat_busy_n2", busy0, 0);

    // Tick outside the run state does nothing.
    @(negedge clk);
    op = 3'd1; state = 3'd2; tick = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tick = 1'b0;
      if (busy0 || done0) seen = 1;
    end
    chk("idle_tick_activity", seen, 0);
    chk("idle_tick_speed", speed0, 5);

    // Ticks while busy: one is kept as pending, the next is dropped.
    @(negedge clk);
    op = 3'd1; boost = 1'b0; state = 3'd1; tick = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) tick = 1'b0;
      if (done0) nd++;
    end
    chk("busy_tick_updates", nd, 2);
    chk("busy_tick_speed", speed0, 15);

    // Reset during VEL aborts the update.
    @(negedge clk);
    op = 3'd1; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_vel_speed", speed0, 0);
    chk("rst_vel_pos_x", pos_x0, 160);
    chk("rst_vel_pos_y", pos_y0, 120);
    chk("rst_vel_busy", busy0, 0);
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done0) nd++;
    end
    chk("rst_vel_no_done", nd, 0);

    // Reverse into the left wall from x=1.
    tick_and_wait(3'd2, 1'b0, 3'd1, got);
    chk("wall1_speed", speed1, -5);
    chk("wall1_pos_x", pos_x1, 0);
    chk("wall1_col", col1, 0);
    chk("wall1_main_speed", speed0, -5);
    tick_and_wait(3'd2, 1'b0, 3'd1, got);
    chk("wall2_pos_x", pos_x1, 0);
    chk("wall2_speed", speed1, 0);
    chk("wall2_col", col1, 1);
    chk("wall2_done", done1, 1);
    chk("wall2_main_pos_x", pos_x0, 158);
    chk("wall2_main_col", col0, 0);

    // Randomized ticks against the model.
    do_reset();
    model_reset();
    for (int k = 0; k < 120; k++) begin
      v = $urandom_range(0, 9);
      if (v <= 3)      rop = 3'd1;
      else if (v == 4) rop = 3'd2;
      else if (v == 5) rop = 3'd3;
      else if (v == 6) rop = 3'd4;
      else if (v == 8) rop = 3'($urandom_range(5, 7));
      else             rop = 3'd0;
      rb = 1'($urandom_range(0, 1));
      rc = $urandom_range(1, 6);
      for (int j = 0; j < rc; j++) begin
        rst_st = 3'd1;
        if ($urandom_range(0, 9) == 0) begin
          rst_st = 3'($urandom_range(0, 7));
          if (rst_st == 3'd1) rst_st = 3'd0;
        end
        tick_and_wait(rop, rb, rst_st, got);
        if (rst_st == 3'd1) begin
          model_step(int'(rop), int'(rb), mcol);
          chk($sformatf("rnd%0d_%0d_done", k, j), got, 1);
          chk($sformatf("rnd%0d_%0d_speed", k, j), speed0, m_spd);
          chk($sformatf("rnd%0d_%0d_angle", k, j), ang0, m_ang);
          chk($sformatf("rnd%0d_%0d_pos_x", k, j), pos_x0, m_px / 64);
          chk($sformatf("rnd%0d_%0d_pos_y", k, j), pos_y0, m_py / 64);
          chk($sformatf("rnd%0d_%0d_col", k, j), col0, mcol);
        end else begin
          chk($sformatf("rnd%0d_%0d_ignored", k, j), got, 0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
